// File: rtl/lsu_port_if.sv
// Request, response and memory-side signals shared between the core, lsu_port and the memory.
interface lsu_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Core and memory side: drives requests and the read word.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );

    // lsu_port side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/lsu_port.sv
// Single-outstanding RV32I load/store port onto a word-wide memory.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module lsu_port #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    lsu_port_if.slave  bus
);
    // Aligned word addresses at or above this limit fall outside the memory.
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES - 3);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;

    state_t      state;
    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [1:0]  cur_lane;
    logic [15:0] cur_wdata;

    logic [31:0] req_aligned;
    logic        f3_ok;
    logic        align_ok;
    logic        req_err;
    logic [31:0] le;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Legality of the request presented at the port.
    always_comb begin
        req_aligned = {bus.req_addr[31:2], 2'b00};
        if (bus.req_we) begin
            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        align_ok = 1'b1;
        if (bus.req_funct3[1:0] == 2'b01) begin
            align_ok = ~bus.req_addr[0];
        end else if (bus.req_funct3[1:0] == 2'b10) begin
            align_ok = (bus.req_addr[1:0] == 2'b00);
        end
        req_err = !(f3_ok && align_ok && (req_aligned < ADDR_LIMIT));
    end

    // Load extraction and store merge on the little-endian view of the read word.
    always_comb begin
        // Memory presents the lowest-addressed byte in the top lane.
        le     = {bus.mem_rdata[7:0], bus.mem_rdata[15:8],
                  bus.mem_rdata[23:16], bus.mem_rdata[31:24]};
        lane_b = le[{cur_lane, 3'b000} +: 8];
        lane_h = le[{cur_lane[1], 4'b0000} +: 16];
        case (cur_funct3)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'h0, lane_b};
            3'b101:  load_val = {16'h0, lane_h};
            default: load_val = le;
        endcase
        merge_val = le;
        if (cur_funct3[1:0] == 2'b00) begin
            merge_val[{cur_lane, 3'b000} +: 8] = cur_wdata[7:0];
        end else begin
            merge_val[{cur_lane[1], 4'b0000} +: 16] = cur_wdata;
        end
    end

    // Control FSM with registered handshake, response and memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            cur_we         <= 1'b0;
            cur_funct3     <= 3'b000;
            cur_lane       <= 2'b00;
            cur_wdata      <= 16'h0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.mem_addr   <= 32'h0;
            bus.mem_wen    <= 1'b0;
            bus.mem_wdata  <= 32'h0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_wen    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req_valid && bus.req_ready) begin
                        cur_we        <= bus.req_we;
                        cur_funct3    <= bus.req_funct3;
                        cur_lane      <= bus.req_addr[1:0];
                        cur_wdata     <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            state          <= StResp;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state         <= StWr;
                            bus.mem_wen   <= 1'b1;
                            bus.mem_addr  <= req_aligned;
                            bus.mem_wdata <= bus.req_wdata;
                        end else begin
                            // Loads and sub-word stores both read the word first.
                            state        <= StRd;
                            bus.mem_addr <= req_aligned;
                        end
                    end
                end
                StRd: begin
                    if (cur_we) begin
                        state         <= StWr;
                        bus.mem_wen   <= 1'b1;
                        bus.mem_wdata <= merge_val;
                    end else begin
                        state          <= StResp;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= load_val;
                        bus.mem_addr   <= 32'h0;
                    end
                end
                StWr: begin
                    state          <= StResp;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.mem_addr   <= 32'h0;
                    bus.mem_wdata  <= 32'h0;
                end
                StResp: begin
                    state         <= StIdle;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: byte-level reference memory, per-cycle output checks, directed + random traffic.
module tb_lsu_port;
    localparam int unsigned MEM_BYTES = 64;
    localparam int AW = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 4;

    logic clk;
    logic rst;
    lsu_port_if bus ();

    lsu_port #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Physical memory attached to the DUT, one little-endian word per entry.
    logic [31:0] phys_w [WORDS];
    logic [31:0] rw;
    // Reference memory as plain bytes.
    logic [7:0]  ref_mem [MEM_BYTES];

    // Expectations for the transaction in flight.
    logic        t_new = 1'b0;
    logic        t_active = 1'b0;
    logic        t_store, t_err;
    int          t_lat, since;
    logic [31:0] t_rdata, t_aligned, t_wword;
    logic [31:0] exp_rdata, exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        rw            = phys_w[bus.mem_addr[AW-1:2]];
        bus.mem_rdata = {rw[7:0], rw[15:8], rw[23:16], rw[31:24]};
    end

    initial forever begin
        @(posedge clk);
        if (!rst && bus.mem_wen === 1'b1) phys_w[bus.mem_addr[AW-1:2]] = bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What a request must produce, derived from byte-addressed memory semantics.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output int lat,
                                  output logic [31:0] rdata, output logic [31:0] aligned,
                                  output logic [31:0] wword);
        int size;
        logic ok_f3;
        logic [31:0] v;
        logic [7:0] b [4];
        aligned = addr & ~32'h3;
        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ok_f3   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err     = !ok_f3 || ((addr & 32'(size - 1)) != 0) || (aligned + 32'd3 >= MEM_BYTES);
        rdata   = 32'h0;
        wword   = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v   = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(ref_mem[AW'(int'(addr) + i)]) << (8 * i);
            if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'h1 << (8 * size)) - 32'h1);
            rdata = v;
        end else begin
            lat = (size == 4) ? 2 : 3;
            for (int i = 0; i < 4; i++) b[i] = ref_mem[AW'(int'(aligned) + i)];
            for (int i = 0; i < size; i++) b[int'(addr - aligned) + i] = wd[8*i +: 8];
            wword = {b[3], b[2], b[1], b[0]};
        end
    endfunction

    // Capture each accepted request and compute its expected outcome.
    initial forever begin
        @(posedge clk);
        if (!rst && bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            model(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata,
                  t_err, t_lat, t_rdata, t_aligned, t_wword);
            t_store = bus.req_we;
            t_new   = 1'b1;
        end
    end

    // Compare every DUT output against the expectations once per cycle.
    initial begin
        logic exp_valid, exp_wen, exp_rd;
        exp_rdata = 32'h0;
        exp_err   = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                t_active = 1'b0;
                t_new    = 1'b0;
                exp_rdata = 32'h0;
                exp_err   = 32'h0;
                chk("rst_ready", bus.req_ready, 1);
                chk("rst_resp_valid", bus.resp_valid, 0);
                chk("rst_resp_rdata", bus.resp_rdata, 0);
                chk("rst_resp_err", bus.resp_err, 0);
                chk("rst_mem_wen", bus.mem_wen, 0);
                chk("rst_mem_addr", bus.mem_addr, 0);
                chk("rst_mem_wdata", bus.mem_wdata, 0);
                continue;
            end
            if (t_new) begin
                t_new    = 1'b0;
                t_active = 1'b1;
                since    = 1;
            end else if (t_active) begin
                since++;
            end
            exp_valid = t_active && since == t_lat;
            exp_wen   = t_active && t_store && !t_err && since == t_lat - 1;
            exp_rd    = t_active && !t_err && since < t_lat && !exp_wen;
            if (exp_valid) begin
                exp_rdata = t_rdata;
                exp_err   = {31'h0, t_err};
                if (t_store && !t_err)
                    for (int i = 0; i < 4; i++) ref_mem[AW'(int'(t_aligned) + i)] = t_wword[8*i +: 8];
            end
            chk("req_ready", bus.req_ready, !(t_active && since <= t_lat));
            chk("resp_valid", bus.resp_valid, exp_valid);
            chk("resp_rdata", bus.resp_rdata, exp_rdata);
            chk("resp_err", bus.resp_err, exp_err);
            chk("mem_wen", bus.mem_wen, exp_wen);
            chk("mem_addr", bus.mem_addr, (exp_wen || exp_rd) ? t_aligned : 32'h0);
            if (exp_wen) chk("mem_wdata", bus.mem_wdata, t_wword);
            else if (!exp_rd) chk("mem_wdata_idle", bus.mem_wdata, 0);
            if (exp_valid) t_active = 1'b0;
        end
    end

    // Issue one request starting at a negedge; return what was observed up to the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit keep,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic [31:0] ww, output logic [31:0] wa, output int nwen,
                          output longint tacc);
        int waited;
        rd = 32'h0; err = 1'b0; lat = 0; ww = 32'h0; wa = 32'h0; nwen = 0; tacc = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        tacc = longint'($time);
        #1;
        if (!keep) bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_wen === 1'b1) begin
                nwen++;
                ww = bus.mem_wdata;
                wa = bus.mem_addr;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL resp_timeout: no resp_valid within 8 cycles, required one");
    endtask

    initial begin
        logic [31:0] rd, ww, wa;
        logic        err;
        int          lat, nwen, mism;
        longint      t1, t2;
        logic [31:0] e_addr [3];
        logic [2:0]  e_f3 [3];
        logic [2:0]  f3_pool [7];

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            phys_w[(AW-2)'(i)] = $urandom;
            for (int j = 0; j < 4; j++) ref_mem[AW'(4 * i + j)] = phys_w[(AW-2)'(i)][8*j +: 8];
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Word store then load back.
        do_req(1'b1, 3'b010, 32'h8, 32'h11223344, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("sw_lat", lat, 2);
        chk("sw_nwen", nwen, 1);
        chk("sw_addr", wa, 32'h8);
        chk("sw_wdata", ww, 32'h11223344);
        chk("sw_byte8", {24'h0, phys_w[2][7:0]}, 32'h44);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rd, 32'h11223344);
        chk("lw_err", err, 0);

        // Byte store as read-modify-write, then both byte-load flavours.
        do_req(1'b1, 3'b000, 32'h9, 32'h000000AA, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("sb_lat", lat, 3);
        chk("sb_wdata", ww, 32'h1122AA44);
        do_req(1'b0, 3'b100, 32'h9, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("lbu_rdata", rd, 32'h000000AA);
        do_req(1'b0, 3'b000, 32'h9, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("lb_rdata", rd, 32'hFFFFFFAA);

        // Halfword load, store, load.
        do_req(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("lh_rdata_pos", rd, 32'h00001122);
        do_req(1'b1, 3'b001, 32'hA, 32'h8001, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("sh_lat", lat, 3);
        chk("sh_wdata", ww, 32'h8001AA44);
        do_req(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
        chk("lh_rdata_neg", rd, 32'hFFFF8001);

        // Rejected loads: misaligned, out of range, illegal width.
        e_addr[0] = 32'h6;  e_f3[0] = 3'b010;
        e_addr[1] = 32'h40; e_f3[1] = 3'b010;
        e_addr[2] = 32'h0;  e_f3[2] = 3'b011;
        for (int k = 0; k < 3; k++) begin
            do_req(1'b0, e_f3[k], e_addr[k], 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t1);
            chk($sformatf("err%0d_lat", k), lat, 1);
            chk($sformatf("err%0d_flag", k), err, 1);
            chk($sformatf("err%0d_rdata", k), rd, 0);
            chk($sformatf("err%0d_nwen", k), nwen, 0);
        end

        // Reset in the middle of the write cycle of a byte store.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h8; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 chk("abort_in_wr", bus.mem_wen, 1);
        #1 rst = 1'b1;
        #1 chk("abort_wen_drop", bus.mem_wen, 0);
        chk("abort_no_resp", bus.resp_valid, 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_kept", phys_w[2], 32'h8001AA44);
        chk("abort_ready", bus.req_ready, 1);

        // Two loads with req_valid held high throughout.
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b1, rd, err, lat, ww, wa, nwen, t1);
        chk("b2b_first", rd, 32'h8001AA44);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, rd, err, lat, ww, wa, nwen, t2);
        chk("b2b_second", rd, 32'h8001AA44);
        chk("b2b_gap_ns", 32'(t2 - t1), 32'd30);

        // Random traffic; per-cycle compare does the checking.
        f3_pool[0] = 3'b000; f3_pool[1] = 3'b001; f3_pool[2] = 3'b010; f3_pool[3] = 3'b100;
        f3_pool[4] = 3'b101; f3_pool[5] = 3'b011; f3_pool[6] = 3'b110;
        for (int n = 0; n < 200; n++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 9) < 9) ? f3_pool[$urandom_range(0, 4)]
                                             : f3_pool[$urandom_range(5, 6)];
            do_req(1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, MEM_BYTES + 7)),
                   $urandom, 1'($urandom_range(0, 3) == 0), rd, err, lat, ww, wa, nwen, t1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);

        mism = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (phys_w[(AW-2)'(i / 4)][8*(i % 4) +: 8] !== ref_mem[AW'(i)]) mism++;
        chk("mem_image_mismatches", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 Parameter MEM_BYTES, default 64: byte size of the attached memory; word-aligned addresses at or above MEM_BYTES-3 are out of range.
REQ-002 clock  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  lsu_port can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, low bits significant for B/H.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits.
REQ-012 resp_err  output  1  request rejected: misaligned, out of range, or illegal funct3.
REQ-013 mem_addr  output  32  memory byte address, always word-aligned.
REQ-014 mem_wen  output  1  memory write enable; memory writes 4 bytes on the rising edge.
REQ-015 mem_wdata  output  32  write word; bits [7:0] land at mem_addr, bits [31:24] at mem_addr+3.
REQ-016 mem_rdata  input  32  combinational read word; byte at mem_addr is in bits [31:24], byte at mem_addr+3 in bits [7:0].

Function
REQ-017 States: IDLE, RD, WR, RESP; only IDLE asserts req_ready.
REQ-018 Accept on req_valid && req_ready; capture req_we, funct3, addr and wdata in that edge.
REQ-019 Error checks at accept: H/HU require addr[0]=0; W requires addr[1:0]=0; loads allow funct3 {000,001,010,100,101} only; stores allow {000,001,010} only; range check per REQ-001.
REQ-020 Error request: go to RESP with resp_err=1 and resp_rdata=0; no mem_wen pulse.
REQ-021 Load: IDLE->RD->RESP; in RD, mem_addr={addr[31:2],2'b00}; lsu_port samples mem_rdata at the end of RD.
REQ-022 Load data: form the little-endian word LE by byte-swapping mem_rdata; select the lane by addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-023 SW: IDLE->WR->RESP; in WR, mem_wen=1, mem_addr aligned, mem_wdata=req_wdata.
REQ-024 SB/SH: IDLE->RD->WR->RESP (read-modify-write). In RD, sample LE. In WR, mem_wdata=LE with lane addr[1:0] replaced by wdata[7:0] (SB), or lanes addr[1]*2 and addr[1]*2+1 replaced by wdata[15:0] (SH).
REQ-025 Latency, for accept in cycle N: error responds at N+1; load and SW at N+2; SB and SH at N+3.
REQ-026 RESP lasts exactly one cycle with resp_valid=1, with no backpressure; next state is IDLE, so req_ready=1 at RESP+1.
REQ-027 resp_rdata and resp_err are registered; they update only on entry to RESP and hold until the next response; stores return resp_rdata=0.
REQ-028 mem_wen=1 only in WR; in IDLE and RESP, mem_addr=0 and mem_wdata=0.
REQ-029 req_valid while busy is ignored and not queued; the core holds the request until it is accepted.

Reset
REQ-030 reset forces IDLE immediately and asynchronously: mem_wen=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, req_ready=1 after release.
REQ-031 Reset during RD or WR aborts the request with no response; if reset precedes the WR edge, no write occurs.

Verification
REQ-032 SW 0x8, 0x11223344 -> WR cycle shows mem_addr=0x8, mem_wen=1, mem_wdata=0x11223344, and the model holds mem[8]=0x44; then LW 0x8 -> resp_rdata=0x11223344 at N+2, resp_err=0.
REQ-033 SB 0x9, 0x000000AA on that word -> RD then WR with mem_wdata=0x1122AA44 at N+3; LBU 0x9 -> 0x000000AA; LB 0x9 -> 0xFFFFFFAA.
REQ-034 LH 0xA -> 0x00001122; SH 0xA, 0x8001 -> word becomes 0x8001AA44; LH 0xA -> 0xFFFF8001.
REQ-035 LW 0x6 (misaligned), LW 0x40 with MEM_BYTES=64, and load funct3=011 -> each gives resp_err=1 at N+1, resp_rdata=0, and no mem_wen.
REQ-036 Reset asserted mid-cycle during WR of SB -> mem_wen drops asynchronously, the memory word is unchanged, and no resp_valid is produced.
REQ-037 req_valid held high across two back-to-back LW requests -> second accepted in the cycle after RESP; req_ready=0 throughout RD and RESP.
